// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Reads back a multiplexed seven-segment display bus and rebuilds the
//   multi-digit BCD value it shows. Each digit must be seen unchanged for
//   STABLE_CYCLES consecutive samples before it is accepted. A frame is
//   complete once every digit position has been accepted. Completed frames
//   are handed out through a valid/ready handshake.
//
// Ports
//   CLK        clock
//   RESET      synchronous, active-high reset
//   SEG        segments {a,b,c,d,e,f,g}, bit 6 = a, 1 = lit
//   DIGIT_SEL  one-hot digit currently driven on SEG
//   OUT_READY  consumer takes VALUE this cycle
//   OUT_VALID  VALUE/DIGIT_ERR hold a complete frame
//   VALUE      BCD nibbles, nibble i = digit i
//   DIGIT_ERR  bit i set: digit i was a dash or an undecodable pattern
//   OVERRUN    sticky: a completed frame was dropped while the output was full
//   STALE      one-cycle pulse: a partial frame was discarded after going idle
module seven_segment_capture #(
    parameter int N_DIGITS       = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [6:0]            SEG,
    input  logic [N_DIGITS-1:0]   DIGIT_SEL,
    input  logic                  OUT_READY,
    output logic                  OUT_VALID,
    output logic [4*N_DIGITS-1:0] VALUE,
    output logic [N_DIGITS-1:0]   DIGIT_ERR,
    output logic                  OVERRUN,
    output logic                  STALE
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
    // Accept on the edge where the count steps from STABLE_CYCLES-2 to STABLE_CYCLES-1.
    localparam logic [CW-1:0] CNT_ACC  = CW'(STABLE_CYCLES - 2);
    // The counter never shows TIMEOUT_CYCLES-1: the edge that would reach it discards instead.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic {EMPTY, FULL} out_state_e;

    // Returns {err, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b0000001: r = 5'h1F;
            default:    r = 5'h1E;
        endcase
        return r;
    endfunction

    logic [6:0]            seg_q;
    logic [N_DIGITS-1:0]   sel_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_DIGITS-1:0]   mask_q, mask_d;
    logic [4*N_DIGITS-1:0] nib_q;
    logic [N_DIGITS-1:0]   err_q;
    logic                  done_q;
    logic [TW-1:0]         tmo_q;
    logic                  stale_q;
    out_state_e            state_q;
    logic                  valid_q;
    logic [4*N_DIGITS-1:0] value_q;
    logic [N_DIGITS-1:0]   derr_q;
    logic                  ovr_q;

    logic                  same_d;
    logic                  sel_ok_d;
    logic                  accept_d;
    logic                  complete_d;
    logic [4:0]            dec_d;

    // The incoming bus is the next registered sample, so comparing it with the
    // current registered sample is the "registered vs previous registered" test.
    always_comb begin
        same_d     = (SEG == seg_q) && (DIGIT_SEL == sel_q);
        sel_ok_d   = $onehot(DIGIT_SEL);
        accept_d   = sel_ok_d && same_d && (cnt_q == CNT_ACC);
        dec_d      = decode_seg(seg_q);
        mask_d     = mask_q | sel_q;
        complete_d = accept_d && (mask_d == '1);
        cnt_d      = '0;
        if (sel_ok_d && same_d) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Capture side: input registers, stability, frame collection, idle timeout
    always_ff @(posedge CLK) begin
        if (RESET) begin
            seg_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            nib_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            seg_q   <= SEG;
            sel_q   <= DIGIT_SEL;
            cnt_q   <= cnt_d;
            done_q  <= complete_d;
            stale_q <= 1'b0;
            if (accept_d) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        nib_q[4*i +: 4] <= dec_d[3:0];
                        err_q[i]        <= dec_d[4];
                    end
                end
                // Clearing on completion lets the next frame start on the next accept.
                mask_q <= complete_d ? '0 : mask_d;
                tmo_q  <= '0;
            end else if (mask_q != '0) begin
                if (tmo_q == TMO_LAST) begin
                    mask_q  <= '0;
                    tmo_q   <= '0;
                    stale_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    // Output side: nib_q/err_q stay frozen for at least one edge after completion,
    // so done_q can pick the frame up from the collection buffer directly.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            value_q <= '0;
            derr_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (done_q) begin
                        value_q <= nib_q;
                        derr_q  <= err_q;
                        valid_q <= 1'b1;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (OUT_READY) begin
                        if (done_q) begin
                            value_q <= nib_q;
                            derr_q  <= err_q;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= EMPTY;
                        end
                    end else if (done_q) begin
                        ovr_q <= 1'b1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign OUT_VALID = valid_q;
    assign VALUE     = value_q;
    assign DIGIT_ERR = derr_q;
    assign OVERRUN   = ovr_q;
    assign STALE     = stale_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture
//   Directed scenarios plus a randomized scan, all compared each cycle against
//   a behavioural model that works in terms of sample run lengths, a set of
//   captured digit positions and an output slot.
module tb_seven_segment_capture;

    localparam int N = 8;
    localparam int S = 4;
    localparam int T = 200;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [6:0]    SEG;
    logic [N-1:0]  DIGIT_SEL;
    logic          OUT_READY;
    logic          OUT_VALID;
    logic [4*N-1:0] VALUE;
    logic [N-1:0]  DIGIT_ERR;
    logic          OVERRUN;
    logic          STALE;

    seven_segment_capture #(
        .N_DIGITS(N), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK), .RESET(RESET), .SEG(SEG), .DIGIT_SEL(DIGIT_SEL),
        .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .VALUE(VALUE),
        .DIGIT_ERR(DIGIT_ERR), .OVERRUN(OVERRUN), .STALE(STALE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] pat[10];

    // Reference model state
    bit          m_have_prev;
    logic [6:0]  m_prev_seg;
    logic [N-1:0] m_prev_sel;
    int          m_run;
    bit          m_got[N];
    logic [3:0]  m_nib[N];
    bit          m_err[N];
    int          m_idle;
    bit          m_pending;
    logic [31:0] m_pend_val;
    logic [N-1:0] m_pend_err;
    bit          exp_valid;
    logic [31:0] exp_value;
    logic [N-1:0] exp_err;
    bit          exp_ovr;
    bit          exp_stale;

    // Observed handshake transfers and STALE pulses
    int          dut_xfers = 0;
    logic [31:0] dut_val;
    logic [N-1:0] dut_err;
    int          stale_cnt = 0;

    task automatic ref_decode(input logic [6:0] seg, output logic [3:0] nib, output bit err);
        nib = 4'hE;
        err = 1'b1;
        if (seg == 7'b0000001) nib = 4'hF;
        for (int j = 0; j < 10; j++) begin
            if (seg == pat[j]) begin
                nib = 4'(j);
                err = 1'b0;
            end
        end
    endtask

    function automatic int got_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_got[i]);
        return c;
    endfunction

    task automatic model_edge();
        int idx;
        logic [3:0] nb;
        bit eb;
        if (RESET) begin
            m_have_prev = 0; m_run = 0; m_idle = 0; m_pending = 0;
            for (int i = 0; i < N; i++) m_got[i] = 0;
            exp_valid = 0; exp_value = '0; exp_err = '0; exp_ovr = 0; exp_stale = 0;
            return;
        end
        // Output slot: hand off first, then take the frame finished on the previous edge.
        if (exp_valid && OUT_READY) exp_valid = 0;
        if (m_pending) begin
            if (exp_valid) exp_ovr = 1;
            else begin
                exp_valid = 1; exp_value = m_pend_val; exp_err = m_pend_err;
            end
        end
        m_pending = 0;
        exp_stale = 0;
        // Run length of identical samples
        if (m_have_prev && SEG == m_prev_seg && DIGIT_SEL == m_prev_sel) begin
            if (m_run <= S) m_run++;
        end else m_run = 1;
        m_have_prev = 1; m_prev_seg = SEG; m_prev_sel = DIGIT_SEL;
        if ($onehot(DIGIT_SEL) && m_run == S) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (DIGIT_SEL[i]) idx = i;
            ref_decode(SEG, nb, eb);
            m_nib[idx] = nb; m_err[idx] = eb; m_got[idx] = 1;
            m_idle = 0;
            if (got_count() == N) begin
                m_pending = 1;
                for (int i = 0; i < N; i++) begin
                    m_pend_val[4*i +: 4] = m_nib[i];
                    m_pend_err[i] = m_err[i];
                    m_got[i] = 0;
                end
            end
        end else if (got_count() != 0) begin
            m_idle++;
            if (m_idle == T - 1) begin
                for (int i = 0; i < N; i++) m_got[i] = 0;
                m_idle = 0;
                exp_stale = 1;
            end
        end else m_idle = 0;
    endtask

    task automatic step();
        if (!RESET && OUT_VALID === 1'b1 && OUT_READY) begin
            dut_xfers++; dut_val = VALUE; dut_err = DIGIT_ERR;
        end
        @(posedge CLK);
        model_edge();
        #1;
        if (STALE === 1'b1) stale_cnt++;
        check("valid", OUT_VALID, exp_valid);
        check("value", VALUE, exp_value);
        check("digit_err", DIGIT_ERR, exp_err);
        check("overrun", OVERRUN, exp_ovr);
        check("stale", STALE, exp_stale);
    endtask

    task automatic show(input int d, input logic [6:0] p, input int cyc);
        DIGIT_SEL = N'(1) << d;
        SEG = p;
        repeat (cyc) step();
    endtask

    task automatic idle(input int cyc);
        DIGIT_SEL = '0;
        repeat (cyc) step();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    int base;
    int sbase;
    int dig;

    initial begin
        pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        RESET = 1'b1; SEG = '0; DIGIT_SEL = '0; OUT_READY = 1'b1;
        step();
        step();
        check("rst_valid", OUT_VALID, 0);
        check("rst_value", VALUE, 0);
        check("rst_ovr", OVERRUN, 0);
        check("rst_stale", STALE, 0);
        RESET = 1'b0;

        // 1) plain scan of 1..8
        base = dut_xfers;
        for (int i = 0; i < N; i++) show(i, pat[i+1], 6);
        idle(3);
        check("t1_count", dut_xfers - base, 1);
        check("t1_value", dut_val, 32'h87654321);
        check("t1_err", dut_err, 0);

        // 2) dash and an undecodable pattern
        do_reset();
        base = dut_xfers;
        for (int i = 0; i < N; i++) begin
            if (i == 3) show(i, 7'b0000001, 6);
            else if (i == 5) show(i, 7'b0100100, 6);
            else show(i, pat[i], 6);
        end
        idle(3);
        check("t2_count", dut_xfers - base, 1);
        check("t2_value", dut_val, 32'h76E4F210);
        check("t2_err", dut_err, 32'h28);

        // 3) dwell one sample too short
        do_reset();
        base = dut_xfers;
        for (int i = 0; i < N; i++) show(i, pat[i], S - 1);
        idle(5);
        check("t3_valid", OUT_VALID, 0);
        check("t3_count", dut_xfers - base, 0);

        // 4) consumer stalled across two frames
        do_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < N; i++) show(i, pat[8-i], 6);
        for (int i = 0; i < N; i++) show(i, pat[9], 6);
        idle(3);
        check("t4_held_valid", OUT_VALID, 1);
        check("t4_held_value", VALUE, 32'h12345678);
        check("t4_overrun", OVERRUN, 1);
        base = dut_xfers;
        OUT_READY = 1'b1;
        step();
        check("t4_drained", OUT_VALID, 0);
        check("t4_xfer", dut_val, 32'h12345678);
        check("t4_count", dut_xfers - base, 1);

        // 5) partial frame times out
        do_reset();
        check("t5_ovr_cleared", OVERRUN, 0);
        base = dut_xfers;
        sbase = stale_cnt;
        for (int i = 0; i < 4; i++) show(i, pat[0], 6);
        idle(T + 5);
        check("t5_stale_pulses", stale_cnt - sbase, 1);
        for (int i = 4; i < N; i++) show(i, pat[5], 6);
        for (int i = 0; i < 4; i++) show(i, pat[5], 6);
        idle(4);
        check("t5_count", dut_xfers - base, 1);
        check("t5_value", dut_val, 32'h55555555);

        // 6) multi-hot select, then reset in the middle of a frame
        do_reset();
        base = dut_xfers;
        SEG = pat[4];
        DIGIT_SEL = 8'b0000_0011;
        repeat (10) step();
        for (int i = 2; i < N; i++) show(i, pat[i], 6);
        idle(3);
        check("t6_multihot_valid", OUT_VALID, 0);
        check("t6_multihot_count", dut_xfers - base, 0);
        do_reset();
        check("t6_rst_valid", OUT_VALID, 0);
        check("t6_rst_value", VALUE, 0);
        check("t6_rst_err", DIGIT_ERR, 0);
        for (int i = 0; i < 2; i++) show(i, pat[i], 6);
        idle(3);
        check("t6_mask_empty", dut_xfers - base, 0);

        // Randomized scanning
        do_reset();
        dig = 0;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 19) == 0) DIGIT_SEL = N'($urandom);
            else if ($urandom_range(0, 4) == 0) DIGIT_SEL = N'(1) << $urandom_range(0, N - 1);
            else begin
                DIGIT_SEL = N'(1) << dig;
                dig = (dig + 1) % N;
            end
            case ($urandom_range(0, 11))
                10:      SEG = 7'b0000001;
                11:      SEG = 7'($urandom);
                default: SEG = pat[$urandom_range(0, 9)];
            endcase
            OUT_READY = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 8)) step();
            if ($urandom_range(0, 59) == 0) idle(T + 10);
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
